// File: rtl/integer_execution_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : integer_execution_stage_if
//  Purpose  : Issue, recovery, bypass and writeback bundle for the integer
//             execution stage.
//  Revision : 1.0
// ============================================================================
interface integer_execution_stage_if #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 7,
    parameter int AL_W   = 6
);
    logic              stall;
    logic              clear;
    logic              in_valid;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_opA;
    logic [DATA_W-1:0] in_opB;
    logic              in_opA_valid;
    logic              in_opB_valid;
    logic              in_write_reg;
    logic [PREG_W-1:0] in_dst;
    logic [AL_W-1:0]   in_al_ptr;
    logic              rec_phase;
    logic              rec_flush_all;
    logic [AL_W-1:0]   rec_head;
    logic [AL_W-1:0]   rec_tail;
    logic              byp_valid;
    logic [PREG_W-1:0] byp_dst;
    logic [DATA_W-1:0] byp_data;
    logic              wb_valid;
    logic              wb_write_reg;
    logic [PREG_W-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic [AL_W-1:0]   wb_al_ptr;
    logic              replay;

    modport master (
        output stall, clear, in_valid, in_op, in_opA, in_opB,
               in_opA_valid, in_opB_valid, in_write_reg, in_dst, in_al_ptr,
               rec_phase, rec_flush_all, rec_head, rec_tail,
        input  byp_valid, byp_dst, byp_data,
               wb_valid, wb_write_reg, wb_dst, wb_data, wb_al_ptr, replay
    );

    modport slave (
        input  stall, clear, in_valid, in_op, in_opA, in_opB,
               in_opA_valid, in_opB_valid, in_write_reg, in_dst, in_al_ptr,
               rec_phase, rec_flush_all, rec_head, rec_tail,
        output byp_valid, byp_dst, byp_data,
               wb_valid, wb_write_reg, wb_dst, wb_data, wb_al_ptr, replay
    );
endinterface
`default_nettype wire

// File: rtl/integer_execution_stage.sv
`default_nettype none
// ============================================================================
//  Module   : integer_execution_stage
//  Purpose  : Latches one register-read lane, runs a single-cycle ALU op,
//             drives bypass and registers the result for writeback/replay.
//  Revision : 1.0
// ============================================================================
module integer_execution_stage #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 7,
    parameter int AL_W   = 6
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    integer_execution_stage_if.slave  bus
);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_SLL   = 4'd5;
    localparam logic [3:0] c_OP_SRL   = 4'd6;
    localparam logic [3:0] c_OP_SRA   = 4'd7;
    localparam logic [3:0] c_OP_SLT   = 4'd8;
    localparam logic [3:0] c_OP_SLTU  = 4'd9;
    localparam logic [3:0] c_OP_PASSB = 4'd10;

    // Stage register S
    logic              r_s_valid_q,     w_s_valid_d;
    logic [3:0]        r_s_op_q,        w_s_op_d;
    logic [DATA_W-1:0] r_s_opa_q,       w_s_opa_d;
    logic [DATA_W-1:0] r_s_opb_q,       w_s_opb_d;
    logic              r_s_opa_valid_q, w_s_opa_valid_d;
    logic              r_s_opb_valid_q, w_s_opb_valid_d;
    logic              r_s_write_reg_q, w_s_write_reg_d;
    logic [PREG_W-1:0] r_s_dst_q,       w_s_dst_d;
    logic [AL_W-1:0]   r_s_al_ptr_q,    w_s_al_ptr_d;

    // Writeback register W
    logic              r_wb_valid_q,     w_wb_valid_d;
    logic              r_wb_replay_q,    w_wb_replay_d;
    logic              r_wb_write_reg_q, w_wb_write_reg_d;
    logic [PREG_W-1:0] r_wb_dst_q,       w_wb_dst_d;
    logic [DATA_W-1:0] r_wb_data_q,      w_wb_data_d;
    logic [AL_W-1:0]   r_wb_al_ptr_q,    w_wb_al_ptr_d;

    logic              w_flush;
    logic              w_live;
    logic              w_fault;
    logic [DATA_W-1:0] w_alu_res;
    logic [4:0]        w_shamt;

    // Active-list range [head, tail) is circular; head == tail means empty.
    function automatic logic f_in_range(input logic [AL_W-1:0] p,
                                        input logic [AL_W-1:0] h,
                                        input logic [AL_W-1:0] t);
        logic r;
        r = 1'b0;
        if (h < t)
            r = (p >= h) && (p < t);
        else if (h > t)
            r = (p >= h) || (p < t);
        return r;
    endfunction

    always_comb begin
        w_s_valid_d     = r_s_valid_q;
        w_s_op_d        = r_s_op_q;
        w_s_opa_d       = r_s_opa_q;
        w_s_opb_d       = r_s_opb_q;
        w_s_opa_valid_d = r_s_opa_valid_q;
        w_s_opb_valid_d = r_s_opb_valid_q;
        w_s_write_reg_d = r_s_write_reg_q;
        w_s_dst_d       = r_s_dst_q;
        w_s_al_ptr_d    = r_s_al_ptr_q;
        if (!bus.stall) begin
            w_s_valid_d     = bus.in_valid;
            w_s_op_d        = bus.in_op;
            w_s_opa_d       = bus.in_opA;
            w_s_opb_d       = bus.in_opB;
            w_s_opa_valid_d = bus.in_opA_valid;
            w_s_opb_valid_d = bus.in_opB_valid;
            w_s_write_reg_d = bus.in_write_reg;
            w_s_dst_d       = bus.in_dst;
            w_s_al_ptr_d    = bus.in_al_ptr;
        end
    end

    always_comb begin
        w_flush = bus.rec_phase &&
                  (bus.rec_flush_all || f_in_range(r_s_al_ptr_q, bus.rec_head, bus.rec_tail));
        w_live  = r_s_valid_q && !w_flush && !bus.clear && !bus.stall;
        w_fault = !r_s_opa_valid_q || !r_s_opb_valid_q;
    end

    always_comb begin
        w_shamt   = r_s_opb_q[4:0];
        w_alu_res = '0;
        case (r_s_op_q)
            c_OP_ADD:   w_alu_res = r_s_opa_q + r_s_opb_q;
            c_OP_SUB:   w_alu_res = r_s_opa_q - r_s_opb_q;
            c_OP_AND:   w_alu_res = r_s_opa_q & r_s_opb_q;
            c_OP_OR:    w_alu_res = r_s_opa_q | r_s_opb_q;
            c_OP_XOR:   w_alu_res = r_s_opa_q ^ r_s_opb_q;
            c_OP_SLL:   w_alu_res = r_s_opa_q << w_shamt;
            c_OP_SRL:   w_alu_res = r_s_opa_q >> w_shamt;
            c_OP_SRA:   w_alu_res = $unsigned($signed(r_s_opa_q) >>> w_shamt);
            c_OP_SLT:   w_alu_res = {{(DATA_W-1){1'b0}},
                                     ($signed(r_s_opa_q) < $signed(r_s_opb_q))};
            c_OP_SLTU:  w_alu_res = {{(DATA_W-1){1'b0}}, (r_s_opa_q < r_s_opb_q)};
            c_OP_PASSB: w_alu_res = r_s_opb_q;
            default:    w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_wb_valid_d     = r_wb_valid_q;
        w_wb_replay_d    = r_wb_replay_q;
        w_wb_write_reg_d = r_wb_write_reg_q;
        w_wb_dst_d       = r_wb_dst_q;
        w_wb_data_d      = r_wb_data_q;
        w_wb_al_ptr_d    = r_wb_al_ptr_q;
        if (!bus.stall) begin
            w_wb_valid_d     = w_live && !w_fault;
            w_wb_replay_d    = w_live && w_fault;
            w_wb_write_reg_d = r_s_write_reg_q && !w_fault;
            w_wb_dst_d       = r_s_dst_q;
            w_wb_data_d      = w_alu_res;
            w_wb_al_ptr_d    = r_s_al_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_valid_q      <= 1'b0;
            r_s_op_q         <= '0;
            r_s_opa_q        <= '0;
            r_s_opb_q        <= '0;
            r_s_opa_valid_q  <= 1'b0;
            r_s_opb_valid_q  <= 1'b0;
            r_s_write_reg_q  <= 1'b0;
            r_s_dst_q        <= '0;
            r_s_al_ptr_q     <= '0;
            r_wb_valid_q     <= 1'b0;
            r_wb_replay_q    <= 1'b0;
            r_wb_write_reg_q <= 1'b0;
            r_wb_dst_q       <= '0;
            r_wb_data_q      <= '0;
            r_wb_al_ptr_q    <= '0;
        end else begin
            r_s_valid_q      <= w_s_valid_d;
            r_s_op_q         <= w_s_op_d;
            r_s_opa_q        <= w_s_opa_d;
            r_s_opb_q        <= w_s_opb_d;
            r_s_opa_valid_q  <= w_s_opa_valid_d;
            r_s_opb_valid_q  <= w_s_opb_valid_d;
            r_s_write_reg_q  <= w_s_write_reg_d;
            r_s_dst_q        <= w_s_dst_d;
            r_s_al_ptr_q     <= w_s_al_ptr_d;
            r_wb_valid_q     <= w_wb_valid_d;
            r_wb_replay_q    <= w_wb_replay_d;
            r_wb_write_reg_q <= w_wb_write_reg_d;
            r_wb_dst_q       <= w_wb_dst_d;
            r_wb_data_q      <= w_wb_data_d;
            r_wb_al_ptr_q    <= w_wb_al_ptr_d;
        end
    end

    assign bus.byp_valid    = w_live && r_s_write_reg_q && !w_fault;
    assign bus.byp_dst      = r_s_dst_q;
    assign bus.byp_data     = w_alu_res;
    assign bus.wb_valid     = r_wb_valid_q;
    assign bus.wb_write_reg = r_wb_write_reg_q;
    assign bus.wb_dst       = r_wb_dst_q;
    assign bus.wb_data      = r_wb_data_q;
    assign bus.wb_al_ptr    = r_wb_al_ptr_q;
    assign bus.replay       = r_wb_replay_q;

endmodule
`default_nettype wire

// File: doc/integer_execution_stage.md
# integer_execution_stage

Integer execution stage directly downstream of integer register read. Captures one register-read lane per cycle into its pipeline register, evaluates a single-cycle integer ALU op on the latched operands, and registers the result for register writeback. It also drives the bypass result for the current cycle and raises a replay request when a register operand arrived without a valid value. Stall, clear and selective (active-list range) flush follow the same rules as the rest of the integer back end.

## Interface
- `DATA_W`, 32: operand/result width.
- `PREG_W`, 7: physical destination register number width.
- `AL_W`, 6: active-list pointer width; the pointer space is 2^AL_W entries, circular.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: back-end stall; holds all registers.
- `clear` in 1: back-end clear; kills the ops being produced this cycle.
- `in_valid` in 1: op present from register read.
- `in_op` in 4: ALU op code.
- `in_opA`, `in_opB` in DATA_W: operand data.
- `in_opA_valid`, `in_opB_valid` in 1: operand data is valid.
- `in_write_reg` in 1: op writes a destination.
- `in_dst` in PREG_W: physical destination.
- `in_al_ptr` in AL_W: active-list pointer of the op.
- `rec_phase` in 1: recovery in progress.
- `rec_flush_all` in 1: flush every op.
- `rec_head`, `rec_tail` in AL_W: flush range [head, tail).
- `byp_valid` out 1: bypass result valid (combinational).
- `byp_dst` out PREG_W: bypass destination.
- `byp_data` out DATA_W: bypass data.
- `wb_valid` out 1: registered writeback valid.
- `wb_write_reg` out 1: registered destination-write enable.
- `wb_dst` out PREG_W: registered destination.
- `wb_data` out DATA_W: registered result.
- `wb_al_ptr` out AL_W: registered active-list pointer.
- `replay` out 1: registered request to reissue `wb_al_ptr`'s op.

## Operation
- Stage register S holds the in_* fields. On rst, S.valid = 0. Otherwise, when !stall, S loads all in_* fields. When stall, S holds.
- Flush check on S: flush = rec_phase && (rec_flush_all || inRange(S.al_ptr)).
  - When head < tail, inRange is head ≤ p < tail.
  - When head > tail (wrap-around), inRange is p ≥ head || p < tail.
  - When head == tail, the range is empty.
- Live = S.valid && !flush && !clear && !stall.
- Operand fault = !S.opA_valid || !S.opB_valid.
- ALU, result truncated to DATA_W:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, using shift amount opB[4:0].
  - 8 SLT (signed), 9 SLTU.
  - 10 PASSB (returns opB).
  - 11–15 return 0.
- Bypass outputs:
  - byp_valid = Live && S.write_reg && !fault.
  - byp_dst = S.dst.
  - byp_data = ALU result.
- Writeback register W:
  - On rst: wb_valid = 0, replay = 0, and all other wb_* = 0.
  - When !stall: wb_valid ← Live && !fault; replay ← Live && fault; wb_write_reg ← S.write_reg && !fault; wb_dst, wb_data, wb_al_ptr ← S fields and ALU result.
  - When stall: W holds.
- A faulted op never sets wb_valid or byp_valid.

## Timing
- In_* sampled at edge N appear on byp_* during cycle N..N+1.
- The same result appears on wb_* after edge N+1, so writeback latency is 2 edges.
- Throughput is one op per cycle.
- When stall and clear are asserted together, stall wins: S and W both hold.
- Recovery asserted while S holds an in-range op: no byp_valid that cycle, and wb_valid = 0 after the next edge. Ops already in W are not re-flushed.
- rst asserted mid-stream: both S.valid and wb_valid are 0 after that edge, regardless of stall.

## Test plan
- ADD: opA=5, opB=0xFFFFFFFF → byp_data = 4 in the cycle after capture; wb_data = 4 with wb_valid = 1 one edge later. SRA: opA=0x80000000, opB=4 → wb_data = 0xF8000000. SLTU: 1 vs 0xFFFFFFFF → 1.
- Operand fault: in_opB_valid = 0 → byp_valid = 0, replay = 1, wb_valid = 0, wb_al_ptr equals the op's pointer.
- Stall: stall for 3 cycles with a live op in S → wb_* unchanged and no new capture. After release, the held op completes exactly once.
- Flush range, AL_W=6:
  - head=60, tail=2, ptrs 61 and 1 → flushed.
  - head=60, tail=2, ptr 2 → completes.
  - head=tail=10, ptr 10 → completes.
  - rec_flush_all → any ptr flushed.
- Clear: clear=1 with a valid op → byp_valid = 0, wb_valid = 0 next edge.
- Reset: reset while ops are in S and W, with stall=1 → wb_valid = 0 and replay = 0 after the edge. The first op issued after reset completes normally.
